// File: rtl/instr_mem_ldr.sv
// Instruction memory with a power-on clear sweep, a registered 1-cycle fetch port and a
// handshaked program loader. State machine: CLEAR -> RUN <-> LOAD.
module instr_mem_ldr #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WORD_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              pc_fault,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough to compare the full word index against DEPTH without truncation.
    localparam int unsigned CMP_W = (ADDR_W > 32) ? ADDR_W : 32;
    // Byte-offset bits inside one word; any of them set means a misaligned pc.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << WORD_SHIFT) - 64'd1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StClear,
        StRun,
        StLoad
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_ptr;
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_valid;
    logic              r_pc_fault;
    logic              r_load_done;

    logic [ADDR_W-1:0] w_idx_full;
    logic [CMP_W-1:0]  w_idx_ext;
    logic [IDX_W-1:0]  w_idx;
    logic              w_misalign;
    logic              w_oor;
    logic              w_fault;
    logic              w_fetch;
    logic              w_accept;
    logic              w_load_end;

    // Fetch address decode and load handshake qualification.
    always_comb begin
        w_idx_full = pc >> WORD_SHIFT;
        w_idx_ext  = CMP_W'(w_idx_full);
        w_idx      = w_idx_full[IDX_W-1:0];
        w_misalign = |(pc & LOW_MASK);
        w_oor      = (w_idx_ext >= CMP_W'(DEPTH));
        w_fault    = w_misalign | w_oor;
        w_fetch    = fetch_req && (r_state == StRun);
        w_accept   = load_valid && (r_state == StLoad);
        w_load_end = w_accept && (load_last || (r_wr_ptr == LAST_IDX));
    end

    // Memory write port: zero sweep while clearing, program words while loading.
    always_ff @(posedge clk) begin
        if (r_state == StClear) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_accept) begin
            r_mem[r_wr_ptr] <= load_data;
        end
    end

    // Control FSM with registered fetch and load-completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StClear;
            r_clr_ptr     <= '0;
            r_wr_ptr      <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_fault    <= 1'b0;
            r_load_done   <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch;
            r_load_done   <= w_load_end;
            // instr and pc_fault hold their value unless a fetch completes.
            if (w_fetch) begin
                r_pc_fault <= w_fault;
                r_instr    <= w_fault ? '0 : r_mem[w_idx];
            end
            unique case (r_state)
                StClear: begin
                    if (r_clr_ptr == LAST_IDX) begin
                        r_clr_ptr <= '0;
                        r_state   <= StRun;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + IDX_W'(1);
                    end
                end
                StRun: begin
                    // A fetch in this same cycle is still served above.
                    if (load_start) begin
                        r_wr_ptr <= '0;
                        r_state  <= StLoad;
                    end
                end
                StLoad: begin
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + IDX_W'(1);
                        if (w_load_end) begin
                            r_state <= StRun;
                        end
                    end
                end
                default: r_state <= StClear;
            endcase
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_fault    = r_pc_fault;
    assign load_done   = r_load_done;
    assign load_ready  = (r_state == StLoad);
    assign busy        = (r_state != StRun);

endmodule
